// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency synchronous
// instruction memory and holds the IF/ID pipeline register.
module fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus1,
  output logic              if_valid,
  output logic [31:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_req_valid;
  logic [31:0]       r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_if_valid;
  logic [31:0]       r_fetch_count;

  // While stalled, re-present the in-flight address so imem_rdata stays on it.
  assign imem_addr   = stall_in ? r_req_pc : r_pc;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus1 = r_if_pc + ONE;
  assign if_valid    = r_if_valid;
  assign fetch_count = r_fetch_count;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let if_pc see the new req_pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_req_valid   <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_valid    <= 1'b0;
      r_fetch_count <= '0;
    end else if (redirect_valid) begin
      r_pc        <= redirect_addr;
      r_req_valid <= 1'b0;
      r_if_valid  <= 1'b0;
    end else if (!stall_in) begin
      r_req_pc    <= r_pc;
      r_req_valid <= 1'b1;
      r_pc        <= r_pc + ONE;
      r_if_instr  <= imem_rdata;
      r_if_pc     <= r_req_pc;
      r_if_valid  <= r_req_valid;
      if (r_req_valid) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a stream-level reference model pushes the
// expected IF/ID state per edge; a negedge monitor pops and compares.
module tb_fetch_stage;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk;
  logic              reset;
  logic              stall_in;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic              if_valid;
  logic [31:0]       fetch_count;

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .if_valid       (if_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  initial imem_rdata = '0;
  always @(posedge clk) imem_rdata <= instr_of(imem_addr);

  typedef struct {
    logic        rst_edge;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] count;
    logic        req_known;
    logic [31:0] req;
    logic [31:0] nxt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Stream model: after a restart at base, the k-th advancing edge delivers base+k-2.
  logic [31:0] m_base  = RESET_PC;
  int          m_adv   = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_count = '0;
  logic        m_req_known = 1'b0;
  logic [31:0] m_req   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic rst, input logic rv, input logic [31:0] ra, input logic st);
    exp_t e;
    reset = rst; redirect_valid = rv; redirect_addr = ra; stall_in = st;
    @(posedge clk);
    if (rst) begin
      m_base = RESET_PC; m_adv = 0; m_valid = 1'b0;
      m_pc = '0; m_instr = '0; m_count = '0;
      m_req_known = 1'b1; m_req = '0;
    end else if (rv) begin
      m_base = ra; m_adv = 0; m_valid = 1'b0; m_req_known = 1'b0;
    end else if (!st) begin
      m_adv++;
      if (m_adv >= 2) begin
        m_valid = 1'b1;
        m_pc    = m_base + 32'(m_adv) - 32'd2;
        m_instr = instr_of(m_pc);
        m_count = m_count + 32'd1;
      end else begin
        m_valid = 1'b0;
      end
      m_req_known = 1'b1;
      m_req       = m_base + 32'(m_adv) - 32'd1;
    end
    #1;
    e.rst_edge = rst; e.valid = m_valid; e.pc = m_pc; e.instr = m_instr;
    e.count = m_count; e.req_known = m_req_known; e.req = m_req;
    e.nxt = m_base + 32'(m_adv);
    q.push_back(e);
  endtask

  // Monitor: compares DUT state after each edge against the queued expectation.
  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      check("if_valid", {31'b0, if_valid}, {31'b0, me.valid});
      check("fetch_count", fetch_count, me.count);
      if (me.valid || me.rst_edge) begin
        check("if_pc", if_pc, me.pc);
        check("if_instr", if_instr, me.instr);
        check("if_pc_plus1", if_pc_plus1, me.pc + 32'd1);
      end
      if (stall_in) begin
        if (me.req_known) check("imem_addr_stall", imem_addr, me.req);
      end else begin
        check("imem_addr", imem_addr, me.nxt);
      end
    end
  end

  initial begin
    reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Free run up to if_pc = 4, then stall three cycles.
    repeat (6) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    // Redirect to 0x40 while if_pc = 7.
    step(0, 1, 32'h40, 0);
    repeat (4) step(0, 0, 0, 0);
    // Redirect and stall on the same edge; then stall during a bubble.
    step(0, 1, 32'h100, 1);
    step(0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    // Second redirect inside the bubbles.
    step(0, 1, 32'h200, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h300, 0);
    repeat (3) step(0, 0, 0, 0);
    // Address wrap.
    step(0, 1, 32'hFFFF_FFFF, 0);
    repeat (4) step(0, 0, 0, 0);
    // Reset in the middle of a two-cycle stall.
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_rv, r_st;
      logic [31:0] r_ra;
      r_rst = ($urandom_range(0, 99) == 0);
      r_rv  = ($urandom_range(0, 9) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_ra  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      step(r_rst, r_rv, r_ra, r_st);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
